// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: 16x oversample strobe, receiver gate, ready/clear
// drain handshake and a fall-through byte FIFO presented as a valid/ready stream.
module uart_rx_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_50m,
  input  logic                          rst,
  input  logic                          enable,
  output logic                          rx_clken,
  output logic                          rx_en,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready_clr,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, CLR} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q;
  logic               rx_clken_q, rx_en_q, rx_ready_clr_q, rx_ready_clr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         mem [FIFO_DEPTH];

  logic capture, full, pop, push, drop, div_wrap;

  assign div_wrap = (div_cnt_q == DIV_W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      rx_clken_q <= 1'b0;
      rx_en_q    <= 1'b1;
    end else begin
      div_cnt_q  <= div_wrap ? '0 : div_cnt_q + 1'b1;
      rx_clken_q <= div_wrap;
      rx_en_q    <= ~enable;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    rx_ready_clr_d = 1'b0;
    capture        = 1'b0;
    case (state_q)
      IDLE: if (rx_ready) begin
        state_d        = CLR;
        rx_ready_clr_d = 1'b1;
        capture        = 1'b1;
      end
      CLR:     state_d = IDLE;  // receiver drops ready on this edge, so ignore it here
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = m_valid && m_ready;
    push      = capture && (!full || pop);
    drop      = capture && full && !pop;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overrun_d = drop | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rx_ready_clr_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_ready_clr_q <= rx_ready_clr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overrun_q      <= overrun_d;
    end
  end

  // NOTE: storage is left unreset; its contents are unobservable while count is 0.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr_q] <= rx_data;
  end

  assign rx_clken     = rx_clken_q;
  assign rx_en        = rx_en_q;
  assign rx_ready_clr = rx_ready_clr_q;
  assign m_valid      = (count_q != '0);
  assign m_data       = mem[rd_ptr_q];
  assign count        = count_q;
  assign overrun      = overrun_q;

endmodule
